// File: rtl/argo_chan_pkg.sv
// Shared definitions for the Argo channel endpoints (receiver and sender).
package argo_chan_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;
  localparam int unsigned FIFO_RD_LAT        = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_READ = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } chan_state_e;

  function automatic logic state_busy(input chan_state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/argo_chan_recv_if.sv
// Bundle of the control-side handshake and the argo_fifo read port of a channel receiver.
interface argo_chan_recv_if
  import argo_chan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
);

  logic                  recv_req;
  logic                  recv_try;
  logic                  chan_closed;
  logic                  recv_done;
  logic                  recv_ok;
  logic [DATA_WIDTH-1:0] recv_data;
  logic                  busy;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  err_overlap;
  logic [CNT_WIDTH-1:0]  recv_count;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport slave (
    input  recv_req, recv_try, chan_closed, fifo_rd_data, fifo_empty,
    output recv_done, recv_ok, recv_data, busy, fifo_rd_en,
           err_overlap, recv_count, stall_count
  );

  modport master (
    output recv_req, recv_try, chan_closed, fifo_rd_data, fifo_empty,
    input  recv_done, recv_ok, recv_data, busy, fifo_rd_en,
           err_overlap, recv_count, stall_count
  );

endinterface

// File: rtl/argo_chan_recv.sv
// Receive endpoint of an Argo channel: converts a control-bit receive into a single
// argo_fifo read and returns a one-cycle completion pulse with the captured value.
module argo_chan_recv
  import argo_chan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter int unsigned CHAN_ID    = 0
) (
  input  logic            clk,
  input  logic            rst,
  argo_chan_recv_if.slave bus
);

  chan_state_e           state_q, state_d;
  logic                  req_s, try_s, any_req_s;

  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic                  unused_chan_id_s;
  assign unused_chan_id_s = (CHAN_ID != 32'd0);

  // A simultaneous try is folded into the blocking request.
  assign req_s     = bus.recv_req;
  assign try_s     = bus.recv_try & ~bus.recv_req;
  assign any_req_s = bus.recv_req | bus.recv_try;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fifo_empty is deliberately ignored in READ and CAPT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          if (!bus.fifo_empty) begin
            state_d = ST_READ;
          end else if (bus.chan_closed) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (try_s) begin
          if (!bus.fifo_empty) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.fifo_empty) begin
          state_d = ST_READ;
        end else if (bus.chan_closed) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values; every output is registered so it lines up with state_q.
  always_comb begin
    rd_en_d = (state_d == ST_READ);
    done_d  = (state_d == ST_DONE);
    busy_d  = state_busy(state_d);

    if (state_q == ST_CAPT) begin
      ok_d   = 1'b1;
      data_d = bus.fifo_rd_data;
    end else if (state_d == ST_DONE) begin
      ok_d   = 1'b0;
      data_d = '0;
    end else begin
      ok_d   = ok_q;
      data_d = data_q;
    end

    if ((req_s && bus.recv_try) || (busy_q && any_req_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if ((state_q == ST_DONE) && ok_q) begin
      rcnt_d = rcnt_q + CNT_WIDTH'(1);
    end else begin
      rcnt_d = rcnt_q;
    end

    // Stall counter saturates rather than wrapping.
    if ((state_q == ST_WAIT) && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Output and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      done_q  <= done_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      stall_q <= stall_d;
    end
  end

  assign bus.recv_done   = done_q;
  assign bus.recv_ok     = ok_q;
  assign bus.recv_data   = data_q;
  assign bus.busy        = busy_q;
  assign bus.fifo_rd_en  = rd_en_q;
  assign bus.err_overlap = err_q;
  assign bus.recv_count  = rcnt_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_argo_chan_recv.sv
// Randomized bench for argo_chan_recv: a queue models argo_fifo, and a transaction-level
// model predicts each completion, its latency and the statistics registers.
module tb_argo_chan_recv;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  argo_chan_recv_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  argo_chan_recv #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CHAN_ID(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];
  bit            prev_rd;
  int            rd_pulses;
  int            done_cnt;
  bit            done_seen;
  int            done_step;
  logic          ok_at_done;
  logic [DW-1:0] data_at_done;

  int m_rcnt;
  int m_stall;
  bit m_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the FIFO model and record what the receiver shows.
  task automatic step(input int s);
    @(posedge clk);
    #1;
    if (prev_rd) begin
      chk("rd_has_data", (fifo_q.size() > 0), 1'b1);
      if (fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
    end
    prev_rd = bus.fifo_rd_en;
    if (bus.fifo_rd_en) rd_pulses++;
    bus.fifo_empty = (fifo_q.size() == 0);
    if (bus.recv_done) begin
      done_cnt++;
      if (!done_seen) begin
        done_seen    = 1'b1;
        done_step    = s;
        ok_at_done   = bus.recv_ok;
        data_at_done = bus.recv_data;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_done",  bus.recv_done,   0);
    chk("rst_ok",    bus.recv_ok,     0);
    chk("rst_data",  bus.recv_data,   0);
    chk("rst_busy",  bus.busy,        0);
    chk("rst_rd_en", bus.fifo_rd_en,  0);
    chk("rst_err",   bus.err_overlap, 0);
    chk("rst_rcnt",  bus.recv_count,  0);
    chk("rst_stall", bus.stall_count, 0);
    m_rcnt  = 0;
    m_stall = 0;
    m_err   = 1'b0;
    prev_rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    bus.fifo_empty = 1'b0;
  endtask

  // op: 0 blocking, 1 try, 2 both. hold: WAIT cycles before data/close appears.
  task automatic run_txn(input int op, input int hold, input bit close_it,
                         input bit poke, input logic [DW-1:0] wdata);
    bit            is_req, is_try, waiting, e_ok;
    logic [DW-1:0] e_data;
    int            e_lat, e_stall_add;
    is_req  = (op != 1);
    is_try  = (op != 0);
    waiting = 1'b0;
    e_stall_add = 0;
    if (op == 2 || poke) m_err = 1'b1;
    if (fifo_q.size() > 0) begin
      e_ok = 1'b1; e_data = fifo_q[0]; e_lat = 3;
    end else if (!is_req || bus.chan_closed) begin
      e_ok = 1'b0; e_data = '0; e_lat = 1;
    end else begin
      waiting = 1'b1;
      e_stall_add = hold + 1;
      if (close_it) begin
        e_ok = 1'b0; e_data = '0; e_lat = hold + 2;
      end else begin
        e_ok = 1'b1; e_data = wdata; e_lat = hold + 4;
      end
    end
    rd_pulses = 0; done_cnt = 0; done_seen = 1'b0; done_step = -1;
    bus.recv_req = is_req;
    bus.recv_try = is_try;
    for (int s = 1; s <= e_lat + 4; s++) begin
      step(s);
      if (s == 1) begin
        bus.recv_req = poke;
        bus.recv_try = 1'b0;
      end else if (s == 2) begin
        bus.recv_req = 1'b0;
      end
      if (waiting && s == hold + 1) begin
        if (close_it) bus.chan_closed = 1'b1;
        else push(wdata);
      end
      if (done_seen) break;
    end
    step(e_lat + 5);
    bus.recv_req = 1'b0;
    bus.recv_try = 1'b0;

    if (e_ok) m_rcnt = (m_rcnt + 1) % (CMAX + 1);
    m_stall = (m_stall + e_stall_add > CMAX) ? CMAX : m_stall + e_stall_add;

    chk("done_latency", done_step,      e_lat);
    chk("done_once",    done_cnt,       1);
    chk("recv_ok",      ok_at_done,     e_ok);
    chk("recv_data",    data_at_done,   e_data);
    chk("rd_pulses",    rd_pulses,      e_ok);
    chk("data_held",    bus.recv_data,  e_data);
    chk("idle_busy",    bus.busy,       0);
    chk("recv_count",   bus.recv_count, m_rcnt);
    chk("stall_count",  bus.stall_count, m_stall);
    chk("err_overlap",  bus.err_overlap, m_err);
  endtask

  initial begin
    bus.recv_req     = 1'b0;
    bus.recv_try     = 1'b0;
    bus.chan_closed  = 1'b0;
    bus.fifo_rd_data = '0;
    bus.fifo_empty   = 1'b1;
    prev_rd          = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    push(32'd5);
    run_txn(0, 0, 1'b0, 1'b0, '0);
    run_txn(0, 6, 1'b0, 1'b0, 32'h0000_ABCD);
    run_txn(1, 0, 1'b0, 1'b0, '0);

    push(32'h1111_0001);
    push(32'h2222_0002);
    bus.chan_closed = 1'b1;
    run_txn(0, 0, 1'b0, 1'b0, '0);
    run_txn(0, 0, 1'b0, 1'b0, '0);
    run_txn(0, 0, 1'b0, 1'b0, '0);
    run_txn(0, 3, 1'b0, 1'b0, '0);
    bus.chan_closed = 1'b0;
    run_txn(0, 2, 1'b1, 1'b0, '0);
    bus.chan_closed = 1'b0;

    push(32'h0000_0077);
    run_txn(0, 0, 1'b0, 1'b1, '0);
    run_txn(2, 1, 1'b0, 1'b0, 32'h0000_0099);
    run_txn(1, 0, 1'b0, 1'b0, '0);

    // Reset while the read is in flight: the popped element is lost.
    push(32'h0000_00A1);
    push(32'h0000_00A2);
    bus.recv_req = 1'b1;
    step(1);
    bus.recv_req = 1'b0;
    step(2);
    do_reset();
    run_txn(0, 0, 1'b0, 1'b0, '0);
    chk("after_rst_data", data_at_done, 32'h0000_00A2);

    for (int i = 0; i < 200; i++) begin
      int op, n;
      if (i % 50 == 49) do_reset();
      n = $urandom_range(0, 3);
      if (n == 3) n = 0;
      for (int k = 0; k < n; k++) if (fifo_q.size() < 16) push($urandom);
      bus.chan_closed = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(0, 9);
      op = (n < 5) ? 0 : ((n < 9) ? 1 : 2);
      run_txn(op, $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
